// File: rtl/ervp_real_clock_alarm_pkg.sv
// Shared definitions for the real-clock alarm: state encodings and default field widths,
// common to the real-clock counter and its bus wrapper.
package ervp_real_clock_alarm_pkg;

    localparam int RCA_BW_TIME    = 64;
    localparam int RCA_BW_PERIOD  = 32;
    localparam int RCA_BW_OVERRUN = 16;
    localparam int RCA_BW_WDATA   = 32;

    typedef logic [1:0] rca_state_t;

    localparam rca_state_t RCA_ST_IDLE  = 2'd0;
    localparam rca_state_t RCA_ST_ARMED = 2'd1;
    localparam rca_state_t RCA_ST_FIRED = 2'd2;

endpackage

// File: rtl/ervp_real_clock_alarm_if.sv
// Control/status bundle of the real-clock alarm; slave = alarm unit, master = bus side.
interface ervp_real_clock_alarm_if import ervp_real_clock_alarm_pkg::*; #(
    parameter int BW_TIME    = RCA_BW_TIME,
    parameter int BW_PERIOD  = RCA_BW_PERIOD,
    parameter int BW_OVERRUN = RCA_BW_OVERRUN
);
    logic [BW_TIME-1:0]      real_clock;
    logic                    alarm_lo_wen;
    logic                    alarm_hi_wen;
    logic [RCA_BW_WDATA-1:0] alarm_wdata;
    logic                    period_wen;
    logic [BW_PERIOD-1:0]    period_wdata;
    logic                    arm;
    logic                    disarm;
    logic                    irq_clear;
    logic                    irq;
    rca_state_t              state;
    logic [BW_TIME-1:0]      alarm_time;
    logic [BW_OVERRUN-1:0]   overrun_count;

    modport slave (
        input  real_clock, alarm_lo_wen, alarm_hi_wen, alarm_wdata, period_wen, period_wdata,
        input  arm, disarm, irq_clear,
        output irq, state, alarm_time, overrun_count
    );

    modport master (
        output real_clock, alarm_lo_wen, alarm_hi_wen, alarm_wdata, period_wen, period_wdata,
        output arm, disarm, irq_clear,
        input  irq, state, alarm_time, overrun_count
    );
endinterface

// File: rtl/ervp_real_clock_alarm_shadow.sv
// Lo/hi staging register for the alarm target; the hi write commits the full word,
// including a lo value written in the same cycle.
module ervp_real_clock_alarm_shadow import ervp_real_clock_alarm_pkg::*; #(
    parameter int BW_TIME = RCA_BW_TIME
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    lo_wen_i,
    input  logic                    hi_wen_i,
    input  logic [RCA_BW_WDATA-1:0] wdata_i,
    output logic                    commit_o,
    output logic [BW_TIME-1:0]      commit_value_o
);
    logic [BW_TIME-1:0] shadow_q, shadow_d;

    always_comb begin
        shadow_d = shadow_q;
        if (lo_wen_i) shadow_d[31:0] = wdata_i;
        if (hi_wen_i) shadow_d[BW_TIME-1:32] = wdata_i[BW_TIME-33:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) shadow_q <= '0;
        else     shadow_q <= shadow_d;
    end

    assign commit_o       = hi_wen_i;
    assign commit_value_o = shadow_d;
endmodule

// File: rtl/ervp_real_clock_alarm.sv
// Alarm/compare unit on the free-running microsecond real clock: one-shot or periodic fire, level irq.
// Optional overrun counter enabled by defining ERVP_REAL_CLOCK_ALARM_OVERRUN_EN.
module ervp_real_clock_alarm import ervp_real_clock_alarm_pkg::*; #(
    parameter int BW_TIME    = RCA_BW_TIME,
    parameter int BW_PERIOD  = RCA_BW_PERIOD,
    parameter int BW_OVERRUN = RCA_BW_OVERRUN
) (
    input  logic                  clk,
    input  logic                  rst,
    ervp_real_clock_alarm_if.slave bus
);
    rca_state_t           state_q, state_d;
    logic [BW_TIME-1:0]   alarm_time_q, alarm_time_d;
    logic [BW_PERIOD-1:0] period_q, period_d;
    logic                 irq_q, irq_d;
    logic [BW_TIME-1:0]   time_diff;
    logic                 reached, fire, commit;
    logic [BW_TIME-1:0]   commit_value;

    ervp_real_clock_alarm_shadow #(.BW_TIME(BW_TIME)) u_shadow (
        .clk            (clk),
        .rst            (rst),
        .lo_wen_i       (bus.alarm_lo_wen),
        .hi_wen_i       (bus.alarm_hi_wen),
        .wdata_i        (bus.alarm_wdata),
        .commit_o       (commit),
        .commit_value_o (commit_value)
    );

    // Wrap-safe: target counts as reached once it is no more than half the range behind now.
    assign time_diff = bus.real_clock - alarm_time_q;
    assign reached   = ~time_diff[BW_TIME-1];
    assign fire      = (state_q == RCA_ST_ARMED) && reached && !bus.disarm;

    always_comb begin
        state_d = state_q;
        if (bus.disarm)
            state_d = RCA_ST_IDLE;
        else if (fire && (period_q == '0))
            state_d = RCA_ST_FIRED;
        else if (bus.arm && (state_q != RCA_ST_ARMED))
            state_d = RCA_ST_ARMED;
    end

    // One period per fire; a late target catches up one step per cycle.
    always_comb begin
        alarm_time_d = alarm_time_q;
        if (commit)
            alarm_time_d = commit_value;
        else if (fire && (period_q != '0))
            alarm_time_d = alarm_time_q + BW_TIME'(period_q);
    end

    always_comb begin
        period_d = period_q;
        if (bus.period_wen) period_d = bus.period_wdata;
    end

    always_comb begin
        irq_d = irq_q;
        if (fire)               irq_d = 1'b1;
        else if (bus.irq_clear) irq_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RCA_ST_IDLE;
            alarm_time_q <= '0;
            period_q     <= '0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            alarm_time_q <= alarm_time_d;
            period_q     <= period_d;
            irq_q        <= irq_d;
        end
    end

`ifdef ERVP_REAL_CLOCK_ALARM_OVERRUN_EN
    logic [BW_OVERRUN-1:0] overrun_q, overrun_d;

    always_comb begin
        overrun_d = overrun_q;
        if (fire && irq_q && !bus.irq_clear && (overrun_q != '1))
            overrun_d = overrun_q + 1'b1;
        else if (bus.irq_clear && !fire)
            overrun_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) overrun_q <= '0;
        else     overrun_q <= overrun_d;
    end

    assign bus.overrun_count = overrun_q;
`else
    assign bus.overrun_count = {BW_OVERRUN{1'b0}};
`endif

    assign bus.irq        = irq_q;
    assign bus.state      = state_q;
    assign bus.alarm_time = alarm_time_q;
endmodule

// File: doc/ervp_real_clock_alarm.md
# ervp_real_clock_alarm

Programmable alarm/compare unit that consumes the free-running 64-bit microsecond real clock and raises an interrupt when a target time is reached. Supports one-shot and periodic modes, with an atomic two-write update of the 64-bit target. Sits beside the real-clock counter in the common peripheral group. Its interrupt goes to the platform interrupt controller.

## Interface
Parameters:
- BW_TIME, 64, width of real_clock and alarm target
- BW_PERIOD, 32, width of period register
- BW_OVERRUN, 16, width of overrun counter

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- real_clock  input  BW_TIME  current time in us, wraps modulo 2^BW_TIME
- alarm_lo_wen  input  1  stage alarm_wdata into low 32 bits of shadow target
- alarm_hi_wen  input  1  write high bits and commit full shadow to active target
- alarm_wdata  input  32  write data for lo/hi
- period_wen  input  1  load period register from period_wdata
- period_wdata  input  BW_PERIOD  period in us; 0 means one-shot
- arm  input  1  single-cycle arm request
- disarm  input  1  single-cycle disarm request
- irq_clear  input  1  clear pending interrupt
- irq  output  1  interrupt pending (level)
- state  output  2  0 IDLE, 1 ARMED, 2 FIRED
- alarm_time  output  BW_TIME  active target
- overrun_count  output  BW_OVERRUN  fires while irq already pending (macro-gated)

## Operation
- Reached condition: MSB of (real_clock - alarm_time) computed modulo 2^BW_TIME equals 0. This is wrap-safe when the target lies within 2^(BW_TIME-1) us of now.
- FSM:
  - IDLE --arm--> ARMED.
  - ARMED, reached and period==0 --> FIRED.
  - ARMED, reached and period!=0 --> stays ARMED, alarm_time <= alarm_time + period (modulo 2^BW_TIME).
  - any state --disarm--> IDLE.
  - FIRED --arm--> ARMED.
- Every fire sets irq. irq_clear clears irq. If a fire and irq_clear occur in the same cycle, set wins.
- Arming with a target already in the past fires on the first ARMED evaluation (late fire). No fire is ever dropped.
- In periodic mode the target advances by exactly one period per fire, even if more than one period is missed. Each cycle therefore catches up once until the target is ahead of real_clock.
- Shadow target:
  - alarm_lo_wen writes shadow[31:0].
  - alarm_hi_wen writes shadow[BW_TIME-1:32] and copies the full shadow into alarm_time in the same edge.
  - A lo write alone never changes alarm_time.
  - A hi commit while ARMED is compared from the next cycle.
  - A commit in the same cycle as a periodic reload: commit wins.
- Simultaneous arm and disarm: disarm wins. arm while ARMED: no effect.
- period_wen while ARMED takes effect at the next reload.

## Timing
- Reset values: state IDLE, irq 0, alarm_time 0, shadow 0, period 0, overrun_count 0.
- Reached is evaluated combinationally from registered state; irq rises one cycle after real_clock first satisfies the condition in ARMED.
- arm at edge N: state ARMED after edge N; the first fire can assert irq after edge N+1.
- Asserting rst mid-operation returns all outputs to their reset values immediately; no pending fire survives reset.

## Configuration
- ERVP_REAL_CLOCK_ALARM_OVERRUN_EN:
  - Defined: overrun_count increments, saturating at all-ones, on every fire occurring while irq is already 1 and not cleared that cycle; cleared when irq_clear is asserted without a simultaneous fire.
  - Undefined: counter logic is omitted and overrun_count is tied to 0.

## Structure
- Shared package/header: state encodings (IDLE/ARMED/FIRED), BW_TIME default and register-field widths, shared with the real-clock counter and the bus wrapper.
- One natural sub-module, ervp_real_clock_alarm_shadow: 64-bit lo/hi staging register with commit strobe.

## Test plan
- Arm with alarm=1000, period=0, real_clock ramps from 990 -> irq rises one cycle after real_clock=1000, state FIRED, stays FIRED at 1010.
- Periodic: alarm=100, period=50 -> fires at 100, 150, 200; alarm_time reads 250 after third fire; state stays ARMED.
- Wrap: alarm=0x0000_0000_0000_0005, real_clock stepping from 0xFFFF_FFFF_FFFF_FFFA -> no fire before wrap, fire at real_clock=5.
- Atomic commit: lo write 0x10 while ARMED with alarm 0x1_0000_0020, real_clock 0x1_0000_0015 -> no fire and alarm_time unchanged; hi write 0x1 -> alarm_time 0x1_0000_0010, fire next cycle.
- Collisions:
  - arm+disarm same cycle -> IDLE.
  - irq_clear coincident with periodic fire -> irq stays 1; with macro defined, overrun_count is 1 after a second uncleared fire.
- rst asserted while ARMED with irq=1 -> irq 0, state IDLE, alarm_time 0 with no clock edge required.
